// File: rtl/bp_me_payload_burst_gen.sv
// Splits one registered message payload into a stream of beat_width_p beats with first/last framing.
// Optional BP_ME_PAYLOAD_WRAP_EN: critical-word-first ordering starting at the beat holding addr_i.
module bp_me_payload_burst_gen #(
  parameter int unsigned data_width_p   = 512,
  parameter int unsigned beat_width_p   = 64,
  parameter int unsigned hdr_width_p    = 64,
  // BedRock mem-cmd payload mask: write and uncached write carry data
  parameter logic [15:0] payload_mask_p = 16'h000A
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,

  input  logic [hdr_width_p-1:0]  header_i,
  input  logic [3:0]              msg_type_i,
  input  logic [2:0]              size_i,
  input  logic [5:0]              addr_i,
  input  logic [data_width_p-1:0] data_i,
  input  logic                    v_i,
  output logic                    ready_and_o,

  output logic [hdr_width_p-1:0]  header_o,
  output logic [beat_width_p-1:0] data_o,
  output logic                    v_o,
  input  logic                    ready_and_i,
  output logic                    first_o,
  output logic                    last_o
);

  localparam int unsigned max_beats_lp = data_width_p / beat_width_p;
  localparam int unsigned cnt_w_lp     = (max_beats_lp > 1) ? $clog2(max_beats_lp) : 1;
  localparam int unsigned data_lg_lp   = (data_width_p > 1) ? $clog2(data_width_p) : 1;
  localparam int unsigned beat_lg_lp   = $clog2(beat_width_p);

  typedef logic [cnt_w_lp-1:0]   cnt_t;
  typedef logic [cnt_w_lp:0]     sum_t;
  typedef logic [data_lg_lp-1:0] didx_t;
  typedef logic [beat_lg_lp-1:0] bidx_t;

  typedef enum logic [0:0] {e_ready, e_stream} state_e;

  state_e                  r_state, w_state_nxt;
  cnt_t                    r_cnt, w_cnt_nxt;
  cnt_t                    r_last, r_start;
  logic                    r_payload;
  logic [2:0]              r_size;
  logic [hdr_width_p-1:0]  r_header;
  logic [data_width_p-1:0] r_data;

  logic                    w_accept, w_hs, w_payload_in;
  int unsigned             w_pbits_in, w_beats_in, w_pmask;
  cnt_t                    w_last_in, w_start_in, w_idx;
  sum_t                    w_sum;
  didx_t                   w_base;
  logic [beat_width_p-1:0] w_beat, w_data;

  assign v_o         = (r_state == e_stream);
  assign first_o     = v_o & (r_cnt == '0);
  assign last_o      = v_o & (r_cnt == r_last);
  assign ready_and_o = (r_state == e_ready) | (v_o & ready_and_i & last_o);
  assign header_o    = r_header;
  assign data_o      = w_data;

  assign w_accept = v_i & ready_and_o;
  assign w_hs     = v_o & ready_and_i;

  // Beat count and start beat of the incoming message, captured at acceptance
  always_comb begin
    w_payload_in = payload_mask_p[msg_type_i];
    w_pbits_in   = 32'd8 << size_i;
    w_beats_in   = w_pbits_in / beat_width_p;
    if (!w_payload_in || (w_beats_in == 0)) begin
      w_beats_in = 1;
    end else if (w_beats_in > max_beats_lp) begin
      w_beats_in = max_beats_lp;
    end
    w_last_in = cnt_t'(w_beats_in - 1);
`ifdef BP_ME_PAYLOAD_WRAP_EN
    w_start_in = cnt_t'(((32'(addr_i) * 32'd8) / beat_width_p) % w_beats_in);
`else
    w_start_in = '0;
`endif
  end

`ifndef BP_ME_PAYLOAD_WRAP_EN
  logic w_unused_addr;
  assign w_unused_addr = ^addr_i;
`endif

  // Emission index = (counter + start) mod beat count; both operands are below the count
  always_comb begin
    w_sum = sum_t'(r_cnt) + sum_t'(r_start);
    w_idx = cnt_t'(w_sum);
    if (w_sum > sum_t'(r_last)) begin
      w_idx = cnt_t'(w_sum - (sum_t'(r_last) + sum_t'(1)));
    end
  end

  always_comb begin
    w_base  = didx_t'(32'(w_idx) * beat_width_p);
    w_beat  = r_data[w_base +: beat_width_p];
    w_pmask = (32'd8 << r_size) - 32'd1;
    w_data  = w_beat;
    if ((32'd8 << r_size) < beat_width_p) begin
      for (int j = 0; j < beat_width_p; j++) begin
        w_data[j] = w_beat[bidx_t'(j) & bidx_t'(w_pmask)];
      end
    end
    if (!r_payload) begin
      w_data = '0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      e_ready: begin
        if (w_accept) begin
          w_state_nxt = e_stream;
          w_cnt_nxt   = '0;
        end
      end
      e_stream: begin
        if (w_hs && last_o) begin
          w_state_nxt = w_accept ? e_stream : e_ready;
          w_cnt_nxt   = '0;
        end else if (w_hs) begin
          w_cnt_nxt = r_cnt + cnt_t'(1);
        end
      end
      default: begin
        w_state_nxt = e_ready;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= e_ready;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_header  <= header_i;
      r_size    <= size_i;
      r_payload <= w_payload_in;
      r_last    <= w_last_in;
      r_start   <= w_start_in;
      r_data    <= data_i;
    end
  end

endmodule

// File: tb/tb_bp_me_payload_burst_gen.sv
// Self-checking bench for bp_me_payload_burst_gen: vector table, corner sequences, random traffic
// checked against a queue-based beat model.
module tb_bp_me_payload_burst_gen;

  localparam int          DW   = 512;
  localparam int          BW   = 64;
  localparam int          HW   = 64;
  localparam int          NB   = DW / BW;
  localparam logic [15:0] MASK = 16'h0002;

  logic          clk_i = 1'b0;
  logic          reset_n_i;
  logic [HW-1:0] header_i, header_o;
  logic [3:0]    msg_type_i;
  logic [2:0]    size_i;
  logic [5:0]    addr_i;
  logic [DW-1:0] data_i;
  logic          v_i, ready_and_o;
  logic [BW-1:0] data_o;
  logic          v_o, ready_and_i, first_o, last_o;

  always #5 clk_i = ~clk_i;

  bp_me_payload_burst_gen #(
    .data_width_p  (DW),
    .beat_width_p  (BW),
    .hdr_width_p   (HW),
    .payload_mask_p(MASK)
  ) dut (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .header_i   (header_i),
    .msg_type_i (msg_type_i),
    .size_i     (size_i),
    .addr_i     (addr_i),
    .data_i     (data_i),
    .v_i        (v_i),
    .ready_and_o(ready_and_o),
    .header_o   (header_o),
    .data_o     (data_o),
    .v_o        (v_o),
    .ready_and_i(ready_and_i),
    .first_o    (first_o),
    .last_o     (last_o)
  );

  typedef struct {
    logic [63:0]   data;
    logic          first;
    logic          last;
    logic [HW-1:0] hdr;
  } beat_t;

  typedef struct {
    logic [3:0]  t;
    logic [2:0]  s;
    int          beats;
    logic [63:0] beat0;
  } vec_t;

  beat_t       q[$];
  beat_t       held, exp_b;
  logic        stall = 1'b0;
  int          n_vec = 0, n_bad = 0;
  int          cur_beats = 0, done_beats = 0;
  logic [63:0] first_data = '0;
  int          rdy_mode = 0;
  vec_t        tbl[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: whole-message view of the expected beat sequence
  task automatic model_push(input logic [HW-1:0] hdr, input logic [3:0] t, input logic [2:0] sz,
                            input logic [5:0] addr, input logic [DW-1:0] d);
    logic [63:0] w[NB];
    logic [15:0] m;
    int          nbytes, n, start;
    beat_t       b;
    m      = MASK;
    nbytes = 1 << sz;
    if (nbytes > DW / 8) nbytes = DW / 8;
    if (!m[t]) begin
      n    = 1;
      w[0] = '0;
    end else if (nbytes * 8 < BW) begin
      n = 1;
      for (int i = 0; i < BW / (nbytes * 8); i++)
        for (int k = 0; k < nbytes * 8; k++) w[0][i*nbytes*8 + k] = d[k];
    end else begin
      n = nbytes * 8 / BW;
      for (int i = 0; i < n; i++) w[i] = d[i*BW +: BW];
    end
    start = 0;
`ifdef BP_ME_PAYLOAD_WRAP_EN
    if (m[t]) start = (int'(addr) * 8 / BW) % n;
`endif
    for (int i = 0; i < n; i++) begin
      b.data  = w[(start + i) % n];
      b.first = (i == 0);
      b.last  = (i == n - 1);
      b.hdr   = hdr;
      q.push_back(b);
    end
  endtask

  always @(posedge clk_i) begin
    #1;
    case (rdy_mode)
      1:       ready_and_i = 1'($urandom() % 2);
      2:       ready_and_i = ~ready_and_i;
      default: ready_and_i = 1'b1;
    endcase
  end

  // Monitor: samples on the falling edge, mid-cycle
  always @(negedge clk_i) begin
    if (!reset_n_i) begin
      q.delete();
      stall = 1'b0;
      chk("reset_v_o", v_o, 0);
    end else begin
      chk("v_o", v_o, q.size() != 0);
      chk("ready_and_o", ready_and_o, (q.size() == 0) || (q.size() == 1 && ready_and_i));
      if (stall) begin
        chk("stall_data", data_o, held.data);
        chk("stall_first", first_o, held.first);
        chk("stall_last", last_o, held.last);
        chk("stall_hdr", header_o, held.hdr);
      end
      stall      = v_o && !ready_and_i;
      held.data  = data_o;
      held.first = first_o;
      held.last  = last_o;
      held.hdr   = header_o;
      if (v_o && ready_and_i && q.size() != 0) begin
        exp_b = q.pop_front();
        chk("beat_data", data_o, exp_b.data);
        chk("beat_first", first_o, exp_b.first);
        chk("beat_last", last_o, exp_b.last);
        chk("beat_hdr", header_o, exp_b.hdr);
        if (first_o) begin
          cur_beats  = 1;
          first_data = data_o;
        end else begin
          cur_beats++;
        end
        if (last_o) done_beats = cur_beats;
      end
      if (v_i && ready_and_o) model_push(header_i, msg_type_i, size_i, addr_i, data_i);
    end
  end

  task automatic send(input logic [3:0] t, input logic [2:0] s, input logic [5:0] a,
                      input logic [DW-1:0] d);
    bit ok = 1'b0;
    header_i   = {$urandom(), $urandom()};
    msg_type_i = t;
    size_i     = s;
    addr_i     = a;
    data_i     = d;
    v_i        = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_i);
      if (ready_and_o) begin
        ok = 1'b1;
        break;
      end
    end
    chk("send_accepted", ok, 1);
    @(posedge clk_i);
    #1;
    v_i = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_i);
      if (q.size() == 0 && !v_o) begin
        ok = 1'b1;
        break;
      end
    end
    chk("drain", ok, 1);
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [DW-1:0] ramp(input int base);
    logic [DW-1:0] d;
    for (int k = 0; k < NB; k++) d[k*BW +: BW] = 64'(base + k);
    return d;
  endfunction

  logic [DW-1:0] tdata, rdata;

  initial begin
    reset_n_i   = 1'b0;
    v_i         = 1'b0;
    header_i    = '0;
    msg_type_i  = '0;
    size_i      = '0;
    addr_i      = '0;
    data_i      = '0;
    ready_and_i = 1'b1;

    for (int k = 0; k < NB; k++) tdata[k*BW +: BW] = 64'hC0DE_0000_0000_BEEF + (64'(k) << 16);
    tbl[0] = '{4'd1, 3'd0, 1, 64'hEFEF_EFEF_EFEF_EFEF};
    tbl[1] = '{4'd1, 3'd1, 1, 64'hBEEF_BEEF_BEEF_BEEF};
    tbl[2] = '{4'd1, 3'd2, 1, 64'h0000_BEEF_0000_BEEF};
    tbl[3] = '{4'd1, 3'd3, 1, 64'hC0DE_0000_0000_BEEF};
    tbl[4] = '{4'd1, 3'd4, 2, 64'hC0DE_0000_0000_BEEF};
    tbl[5] = '{4'd1, 3'd6, 8, 64'hC0DE_0000_0000_BEEF};
    tbl[6] = '{4'd1, 3'd7, 8, 64'hC0DE_0000_0000_BEEF};
    tbl[7] = '{4'd0, 3'd6, 1, 64'h0};
    tbl[8] = '{4'd3, 3'd2, 1, 64'h0};

    #2;
    chk("rst_v_o", v_o, 0);
    chk("rst_first", first_o, 0);
    chk("rst_last", last_o, 0);
    repeat (2) @(posedge clk_i);
    #1 reset_n_i = 1'b1;
    chk("rst_ready", ready_and_o, 1);
    @(posedge clk_i);
    #1;

    // Non-payload: one zero beat, valid the cycle after acceptance
    send(4'd0, 3'd6, 6'd0, tdata);
    chk("np_v", v_o, 1);
    chk("np_first", first_o, 1);
    chk("np_last", last_o, 1);
    chk("np_data", data_o, 0);
    @(posedge clk_i);
    #1;
    chk("np_done", v_o, 0);

    // Full line, word k = k
    done_beats = 0;
    send(4'd1, 3'd6, 6'd0, ramp(0));
    wait_idle();
    chk("line_beats", done_beats, 8);

    for (int i = 0; i < 9; i++) begin
      done_beats = 0;
      first_data = '1;
      send(tbl[i].t, tbl[i].s, 6'd0, tdata);
      wait_idle();
      chk("tbl_beats", done_beats, tbl[i].beats);
      chk("tbl_beat0", first_data, tbl[i].beat0);
    end

    // Backpressure toggling, second message queued behind the last beat
    rdy_mode = 2;
    send(4'd1, 3'd6, 6'd0, ramp(16));
    send(4'd1, 3'd6, 6'd0, ramp(32));
    chk("b2b_v", v_o, 1);
    chk("b2b_first", first_o, 1);
    chk("b2b_data", data_o, 32);
    wait_idle();
    rdy_mode = 0;

`ifdef BP_ME_PAYLOAD_WRAP_EN
    send(4'd1, 3'd6, 6'd24, ramp(0));
    chk("wrap_first", first_o, 1);
    chk("wrap_data0", data_o, 3);
    wait_idle();
`endif

    // Reset during beat 3 of an 8-beat burst
    send(4'd1, 3'd6, 6'd0, ramp(0));
    repeat (3) @(posedge clk_i);
    #1;
    chk("mid_beat3", data_o, 3);
    reset_n_i = 1'b0;
    #1;
    chk("mid_rst_v", v_o, 0);
    chk("mid_rst_first", first_o, 0);
    chk("mid_rst_last", last_o, 0);
    repeat (2) @(posedge clk_i);
    #1 reset_n_i = 1'b1;
    chk("mid_ready", ready_and_o, 1);
    @(posedge clk_i);
    #1;
    send(4'd1, 3'd6, 6'd0, ramp(100));
    chk("mid_restart_first", first_o, 1);
    chk("mid_restart_data", data_o, 100);
    wait_idle();

    // Random traffic against the model
    rdy_mode = 1;
    for (int i = 0; i < 60; i++) begin
      for (int k = 0; k < DW / 32; k++) rdata[k*32 +: 32] = $urandom();
      send(($urandom() % 2 == 0) ? 4'd1 : 4'($urandom() % 16), 3'($urandom() % 8),
           6'($urandom() % 64), rdata);
      repeat ($urandom() % 3) begin
        @(posedge clk_i);
        #1;
      end
    end
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/bp_me_payload_burst_gen.md
BP_ME_PAYLOAD_BURST_GEN -- requirements
Module: bp_me_payload_burst_gen

Interface
REQ-001 SHALL have parameter data_width_p, default 512, maximum message payload width in bits.
REQ-002 SHALL have parameter beat_width_p, default 64, output beat width in bits; a power of two, at least 8 and no greater than data_width_p.
REQ-003 SHALL have parameter hdr_width_p, default 64, opaque header width.
REQ-004 SHALL have parameter payload_mask_p, default mem_cmd_payload_mask_gp, 16 bits; bit k set means msg_type k carries payload.
REQ-005 SHALL have ports clk_i, input, 1, the single clock; all state is on the rising edge.
REQ-006 SHALL have port reset_n_i, input, 1, asynchronous active-low reset.
REQ-007 SHALL have the following input-side ports:
- header_i, input, hdr_width_p, opaque header.
- msg_type_i, input, 4.
- size_i, input, 3; payload bytes = 2^size_i.
- addr_i, input, 6, byte address offset.
- data_i, input, data_width_p.
- v_i, input, 1.
- ready_and_o, output, 1.
REQ-008 SHALL have the following output-side ports:
- header_o, output, hdr_width_p.
- data_o, output, beat_width_p.
- v_o, output, 1.
- ready_and_i, input, 1.
- first_o, output, 1, first beat of a message.
- last_o, output, 1, final beat of a message.

Function
REQ-009 SHALL implement a two-state FSM:
- e_ready: idle.
- e_stream: emitting beats.
REQ-010 SHALL accept a message on v_i & ready_and_o, registering header_i, msg_type_i, size_i, addr_i and data_i.
REQ-011 SHALL assert v_o the cycle after acceptance, giving a latency of 1 cycle.
REQ-012 SHALL drive ready_and_o = (state==e_ready) | (v_o & ready_and_i & last_o), so that back-to-back messages incur no bubble.
REQ-013 SHALL compute the beat count for a payload message as max(1, (8*2^size)/beat_width_p), clamped to data_width_p/beat_width_p.
REQ-014 SHALL emit exactly one beat with data_o=0 and first_o=last_o=1 for a non-payload message (payload_mask_p[msg_type]==0).
REQ-015 SHALL, when the payload is smaller than beat_width_p, replicate the low 8*2^size bits of data across data_o.
REQ-016 SHALL advance the beat counter only on v_o & ready_and_i.
REQ-017 SHALL hold data_o, header_o, first_o and last_o stable while v_o & ~ready_and_i.
REQ-018 SHALL assert first_o on beat index 0 of the emission order only.
REQ-019 SHALL assert last_o on the final beat of the emission order only.
REQ-020 SHALL hold header_o constant across all beats of a message.
REQ-021 SHALL, on the last-beat handshake without a simultaneous accept, return to e_ready with v_o=0 the next cycle.
REQ-022 SHALL, on the last-beat handshake with a simultaneous accept, stay in e_stream and load the new message the next cycle.
REQ-023 SHALL ignore v_i while in e_stream when ready_and_o=0; the input side must hold its message.

Reset
REQ-024 SHALL, on reset_n_i low, immediately drive:
- state = e_ready.
- v_o = 0.
- first_o = 0.
- last_o = 0.
- beat counter = 0.
- ready_and_o = 1, once reset_n_i is high.
REQ-025 SHALL, when reset is asserted mid-burst, discard the remaining beats; no partial message is resumed.
REQ-026 SHALL release reset on reset_n_i rising, taking effect at the next clk_i edge; the data registers need no reset.

Configuration
REQ-027 SHALL support the macro BP_ME_PAYLOAD_WRAP_EN.
- Defined: payload emission starts at beat index (addr_i*8/beat_width_p) mod beat count and wraps modulo beat count (critical-word-first); first_o marks the starting beat and last_o the beat before it in wrapped order.
- Undefined: addr_i is ignored and beats are emitted in ascending order starting at 0.

Verification
REQ-028 SHALL cover a single-beat non-payload message:
- Stimulus: payload_mask_p=16'h0002, msg_type=0, size=6.
- Response: one beat, data_o=0, first_o=last_o=1, v_o exactly 1 cycle after acceptance.
REQ-029 SHALL cover a full-line payload message:
- Stimulus: msg_type=1, size=6, beat_width_p=64, data word k = k.
- Response: 8 beats with data 0..7, first_o on beat 0, last_o on beat 7.
REQ-030 SHALL cover a sub-beat payload:
- Stimulus: msg_type=1, size=1, data_i[15:0]=16'hBEEF.
- Response: one beat, data_o=64'hBEEFBEEFBEEFBEEF.
REQ-031 SHALL cover backpressure with back-to-back messages:
- Stimulus: ready_and_i toggled 1/0 during an 8-beat burst; second message presented at the last beat.
- Response: data stable while stalled; second message's first beat immediately follows with no idle cycle.
REQ-032 SHALL cover wrap ordering:
- Stimulus: BP_ME_PAYLOAD_WRAP_EN defined, addr_i=24, size=6, beat_width_p=64.
- Response: beats emitted in order 3,4,5,6,7,0,1,2; first_o on 3, last_o on 2.
REQ-033 SHALL cover reset mid-burst:
- Stimulus: reset_n_i low during beat 3 of an 8-beat burst.
- Response: v_o falls immediately; after release, ready_and_o=1 and the next message starts at beat 0.
